// File: rtl/register_file.sv
// ----------------------------------------------------------------------------
// register_file
//   Three-port register file: two combinational read ports and one
//   synchronous write port. Register r0 is hardwired to zero.
//
//   There is no handshake on any port. A write is accepted on every rising
//   clk edge where rst_n=1, we3=1 and a3!=0. Reads never stall.
//
//   Optional feature (compile-time macro REGFILE_BYPASS_EN):
//     When defined, a read whose address matches an active write returns
//     wd3 in the same cycle (write-through forwarding), independently per
//     port. When undefined, reads return stored contents only.
//
//   Parameters
//     DATA_WIDTH  register and data-port width (default 32)
//     ADDR_WIDTH  address width; 2**ADDR_WIDTH registers (default 5)
//
//   Ports
//     clk    in   sole clock, rising edge
//     rst_n  in   synchronous active-low reset; clears every register
//     we3    in   write enable for write port 3
//     a1     in   read port 1 address
//     a2     in   read port 2 address
//     a3     in   write port address
//     wd3    in   write data
//     rd1    out  read data for a1
//     rd2    out  read data for a2
// ----------------------------------------------------------------------------
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we3,
  input  logic [ADDR_WIDTH-1:0] a1,
  input  logic [ADDR_WIDTH-1:0] a2,
  input  logic [ADDR_WIDTH-1:0] a3,
  input  logic [DATA_WIDTH-1:0] wd3,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];

  // Qualified write strobe; writes to r0 are dropped here so r0 storage
  // never leaves its reset value.
  logic wr_en;
  assign wr_en = rst_n && we3 && (a3 != '0);

  // Reset has priority over a simultaneous write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[a3] <= wd3;
    end
  end

  // r0 is muxed to zero explicitly so it reads 0 even before the first
  // reset edge.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (a1 != '0) begin
      rd1 = regs[a1];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (a1 == a3)) begin
        rd1 = wd3;
      end
`endif
    end
    if (a2 != '0) begin
      rd2 = regs[a2];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (a2 == a3)) begin
        rd2 = wd3;
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_file.sv
// ----------------------------------------------------------------------------
// tb_register_file
//   Self-checking bench for register_file. Each apply() drives one cycle of
//   inputs, pushes the model's expected rd1/rd2 into exp_q and the sampled
//   DUT outputs into act_q; each test task drains both queues and compares.
//   Define REGFILE_BYPASS_EN for both bench and RTL to check forwarding.
// ----------------------------------------------------------------------------
module tb_register_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // clock / reset block
  logic        clk = 1'b0;
  logic        rst_n;
  logic        we3;
  logic [4:0]  a1, a2, a3;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2;

  always #5 clk = ~clk;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we3  (we3),
    .a1   (a1),
    .a2   (a2),
    .a3   (a3),
    .wd3  (wd3),
    .rd1  (rd1),
    .rd2  (rd2)
  );

  // scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] act_q[$];
  logic [31:0] mdl [32];
  int          vectors = 0;
  int          errors  = 0;

  // Reference read: r0 is zero, optional forwarding, else model contents.
  function automatic logic [31:0] model_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYP && rst_n && we3 && (a3 == a)) return wd3;
    return mdl[a];
  endfunction

  // driver: set inputs (clk low), sample outputs 1ns later
  task automatic apply(input logic r, input logic w, input logic [4:0] x3,
                       input logic [31:0] d, input logic [4:0] x1,
                       input logic [4:0] x2);
    rst_n = r; we3 = w; a3 = x3; wd3 = d; a1 = x1; a2 = x2;
    #1;
    exp_q.push_back(model_rd(x1));
    exp_q.push_back(model_rd(x2));
    act_q.push_back(rd1);
    act_q.push_back(rd2);
  endtask

  // driver: clock edge, update the model alongside the DUT
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    end else if (we3 && a3 != 5'd0) begin
      mdl[a3] = wd3;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] e, g;
    rst_n = 1'b0; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
    tick();
    for (int i = 0; i < 32; i++) apply(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
    rst_n = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = act_q.pop_front(); vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset: got %h expected %h", g, e);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] e, g;
    apply(1'b1, 1'b1, 5'd1, 32'hABCDEFAB, 5'd0, 5'd0); tick();
    apply(1'b1, 1'b1, 5'd2, 32'h01234567, 5'd1, 5'd0); tick();
    apply(1'b1, 1'b1, 5'd3, 32'hCCCCCCCC, 5'd2, 5'd1); tick();
    apply(1'b1, 1'b0, 5'd0, 32'h0, 5'd2, 5'd1);
    apply(1'b1, 1'b0, 5'd0, 32'h0, 5'd2, 5'd3);
    apply(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = act_q.pop_front(); vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL write_read: got %h expected %h", g, e);
      end
    end
  endtask

  task automatic test_overwrite();
    logic [31:0] e, g;
    apply(1'b1, 1'b1, 5'd1, 32'h33334567, 5'd2, 5'd1); tick();
    apply(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = act_q.pop_front(); vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL overwrite: got %h expected %h", g, e);
      end
    end
  endtask

  task automatic test_r0();
    logic [31:0] e, g;
    apply(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0); tick();
    for (int i = 0; i < 32; i++) apply(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = act_q.pop_front(); vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL r0_protect: got %h expected %h", g, e);
      end
    end
  endtask

  task automatic test_we_reset();
    logic [31:0] e, g;
    apply(1'b1, 1'b1, 5'd5, $urandom, 5'd0, 5'd0); tick();
    apply(1'b1, 1'b1, 5'd4, $urandom, 5'd5, 5'd0); tick();
    apply(1'b1, 1'b0, 5'd5, 32'h12345678, 5'd5, 5'd4); tick();
    apply(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd4);
    // reset together with a write to r4: before the edge contents still show
    apply(1'b0, 1'b1, 5'd4, 32'hDEADBEEF, 5'd4, 5'd5); tick();
    apply(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd5);
    // first edge after deassertion must already write
    apply(1'b1, 1'b1, 5'd6, 32'hCAFEF00D, 5'd6, 5'd4); tick();
    apply(1'b1, 1'b0, 5'd0, 32'h0, 5'd6, 5'd4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = act_q.pop_front(); vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL we_reset: got %h expected %h", g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e, g;
    logic [4:0]  w, x;
    for (int i = 0; i < 80; i++) begin
      w = 5'($urandom_range(0, 31));
      x = ($urandom_range(0, 2) == 0) ? w : 5'($urandom_range(0, 31));
      apply(1'b1, 1'($urandom_range(0, 3) != 0), w, $urandom, x,
            5'($urandom_range(0, 31)));
      tick();
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = act_q.pop_front(); vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL back_to_back: got %h expected %h", g, e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    test_reset();
    test_write_read();
    test_overwrite();
    test_r0();
    test_we_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_WIDTH SHALL be provided: default 32, register and data-port width in bits.
REQ-002 Parameter ADDR_WIDTH SHALL be provided: default 5, address width; register count is 2**ADDR_WIDTH (32).
REQ-003 Port clk SHALL be: input, 1 bit, sole clock; all state updates occur on its rising edge.
REQ-004 Port rst_n SHALL be: input, 1 bit, synchronous active-low reset.
REQ-005 Port we3 SHALL be: input, 1 bit, write enable for write port 3.
REQ-006 Port a1 SHALL be: input, ADDR_WIDTH bits, read port 1 address.
REQ-007 Port a2 SHALL be: input, ADDR_WIDTH bits, read port 2 address.
REQ-008 Port a3 SHALL be: input, ADDR_WIDTH bits, write port address.
REQ-009 Port wd3 SHALL be: input, DATA_WIDTH bits, write data.
REQ-010 Port rd1 SHALL be: output, DATA_WIDTH bits, read data for a1.
REQ-011 Port rd2 SHALL be: output, DATA_WIDTH bits, read data for a2.
REQ-012 Port order SHALL be clk, rst_n, we3, a1, a2, a3, wd3, rd1, rd2.

Function
REQ-013 Storage SHALL be 2**ADDR_WIDTH registers of DATA_WIDTH bits, r0..r31.
REQ-014 Reads SHALL be combinational, with zero-cycle latency: rd1 = r[a1] and rd2 = r[a2], updating whenever the address or the stored contents change.
REQ-015 r0 SHALL read as 0 on both ports at all times, regardless of any write attempt.
REQ-016 At a rising clk edge with rst_n=1, we3=1 and a3!=0, r[a3] SHALL take wd3; the new value SHALL be visible on the read ports immediately after that edge.
REQ-017 With we3=0 or a3=0, no register SHALL change.
REQ-018 Both read ports SHALL be independent; a1=a2 SHALL return identical data on both ports.
REQ-019 A read of a3 in the same cycle as a write to a3 SHALL return the old value, unless REGFILE_BYPASS_EN is defined (see REQ-025).
REQ-020 The design SHALL have no handshake and no stall; a write SHALL be accepted on every enabled edge.

Reset
REQ-021 At a rising clk edge with rst_n=0, all registers SHALL clear to 0.
REQ-022 Reset SHALL take priority over a simultaneous write; the write SHALL be discarded.
REQ-023 While rst_n=0, the read ports SHALL still reflect stored contents combinationally, and SHALL read 0 from the first reset edge onward.
REQ-024 Deasserting rst_n SHALL enable writes from the next rising edge, with no dead cycle.

Configuration
REQ-025 With macro REGFILE_BYPASS_EN defined, when rst_n=1, we3=1, a3!=0 and aN=a3, rdN SHALL return wd3 combinationally (write-through forwarding), per port independently.
REQ-026 Without REGFILE_BYPASS_EN, no forwarding logic SHALL exist and reads SHALL return stored contents only.

Verification
REQ-027 Reset: hold rst_n=0 for 1 edge, then sweep a1/a2 over 0..31 -> all reads return 0x00000000.
REQ-028 Write then read: write 0xABCDEFAB to r1, then 0x01234567 to r2, then 0xCCCCCCCC to r3; set a1=2, a2=1 -> rd1=0x01234567, rd2=0xABCDEFAB; set a2=3 -> rd2=0xCCCCCCCC.
REQ-029 Overwrite and same-cycle read: with r1=0xABCDEFAB, write 0x33334567 to r1 while a2=1 -> rd2=0xABCDEFAB before the edge (0x33334567 with bypass), and 0x33334567 after the edge.
REQ-030 r0 protection: write 0xFFFFFFFF to a3=0 with we3=1 -> rd1 with a1=0 stays 0x00000000, and no other register changes.
REQ-031 Write enable and reset priority: we3=0 with a3=5 and wd3=0x12345678 -> r5 is unchanged; assert rst_n=0 together with we3=1 to r4 -> r4 reads 0.
